// File: rtl/io_pkg.sv
// Shared constants, register-select type and helpers for the memory-mapped I/O controller.
package io_pkg;

  localparam logic [7:0] IO_ADDR_OUT    = 8'h00;
  localparam logic [7:0] IO_ADDR_IN     = 8'h01;
  localparam logic [7:0] IO_ADDR_STATUS = 8'h02;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_IRQ      = 4;

  typedef enum logic [1:0] {
    REG_OUT,
    REG_IN,
    REG_STATUS,
    REG_OTHER
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [7:0] addr);
    io_reg_e sel;
    sel = REG_OTHER;
    if (addr == IO_ADDR_OUT)         sel = REG_OUT;
    else if (addr == IO_ADDR_IN)     sel = REG_IN;
    else if (addr == IO_ADDR_STATUS) sel = REG_STATUS;
    return sel;
  endfunction

  // FIFO pointers wrap by natural overflow, so depth must be a power of two.
  function automatic bit depth_ok(input int d);
    return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/io_controller_if.sv
// CPU I/O bus plus TX/RX byte streams of the I/O controller.
interface io_controller_if;
  logic       mem_io;
  logic [7:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output mem_io, addr, wr, rd, wdata, tx_ready, rx_valid, rx_data,
    input  rdata, rdata_oe, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  mem_io, addr, wr, rd, wdata, tx_ready, rx_valid, rx_data,
    output rdata, rdata_oe, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with read/write pointers and an occupancy count; head is always presented.
module io_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("io_fifo: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign head  = r_mem[r_rptr];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: CPU register decode, TX/RX byte FIFOs, sticky overflow status.
// Optional macro IO_CTRL_IRQ_EN adds a registered irq output and STATUS bit 4.
module io_controller
  import io_pkg::*;
#(
  parameter int         DEPTH        = 4,
  parameter logic [7:0] RD_EMPTY_VAL = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  io_controller_if.slave  bus
`ifdef IO_CTRL_IRQ_EN
  ,
  output logic            irq
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  io_reg_e        w_sel;
  logic           w_wr_io;
  logic           w_rd_io;
  logic           w_tx_push;
  logic           w_tx_pop;
  logic           w_rx_push;
  logic           w_rx_pop;
  logic           w_st_clr;
  logic           w_tx_full;
  logic           w_tx_empty;
  logic           w_rx_full;
  logic           w_rx_empty;
  logic           w_stall;
  logic           w_tx_drop;
  logic           w_rx_ovf_set;
  logic           w_irq_bit;
  logic [CW-1:0]  w_tx_count;
  logic [CW-1:0]  w_rx_count;
  logic [7:0]     w_tx_head;
  logic [7:0]     w_rx_head;
  logic [7:0]     w_status;
  logic           w_unused_count;

  logic           r_tx_ovf;
  logic           r_rx_ovf;
  logic [7:0]     r_stall_cnt;

  assign w_sel   = io_decode(bus.addr);
  assign w_wr_io = bus.mem_io & bus.wr;
  // A simultaneous wr+rd is treated as a write; the read side effect (RX pop) is suppressed.
  assign w_rd_io = bus.mem_io & bus.rd & ~bus.wr;

  assign w_tx_push = w_wr_io & (w_sel == REG_OUT);
  assign w_st_clr  = w_wr_io & (w_sel == REG_STATUS);
  assign w_rx_pop  = w_rd_io & (w_sel == REG_IN);

  assign bus.tx_valid = ~w_tx_empty;
  assign bus.tx_data  = w_tx_head;
  assign bus.rx_ready = ~w_rx_full;

  assign w_tx_pop  = bus.tx_valid & bus.tx_ready;
  assign w_rx_push = bus.rx_valid & bus.rx_ready;

  io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .din   (bus.wdata),
    .pop   (w_tx_pop),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count),
    .head  (w_tx_head)
  );

  io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .din   (bus.rx_data),
    .pop   (w_rx_pop),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count),
    .head  (w_rx_head)
  );

  // Occupancy counts are kept for debug visibility only.
  assign w_unused_count = &{1'b0, w_tx_count, w_rx_count};

  assign w_tx_drop    = w_tx_push & w_tx_full & ~w_tx_pop;
  assign w_stall      = bus.rx_valid & ~bus.rx_ready;
  // The 256th consecutive stall cycle is the one that sees the counter already at 255.
  assign w_rx_ovf_set = w_stall & (r_stall_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 8'h00;
    end else if (!w_stall) begin
      r_stall_cnt <= 8'h00;
    end else if (r_stall_cnt != 8'hFF) begin
      r_stall_cnt <= r_stall_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_tx_drop)     r_tx_ovf <= 1'b1;
      else if (w_st_clr) r_tx_ovf <= 1'b0;
      if (w_rx_ovf_set)  r_rx_ovf <= 1'b1;
      else if (w_st_clr) r_rx_ovf <= 1'b0;
    end
  end

`ifdef IO_CTRL_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= ~w_rx_empty | r_rx_ovf | r_tx_ovf;
  end

  assign irq       = r_irq;
  assign w_irq_bit = r_irq;
`else
  assign w_irq_bit = 1'b0;
`endif

  always_comb begin
    w_status              = 8'h00;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_OVF]   = r_rx_ovf;
    w_status[ST_IRQ]      = w_irq_bit;
  end

  assign bus.rdata_oe = bus.mem_io & bus.rd;

  always_comb begin
    bus.rdata = 8'h00;
    if (bus.rdata_oe) begin
      case (w_sel)
        REG_IN:     bus.rdata = w_rx_empty ? RD_EMPTY_VAL : w_rx_head;
        REG_STATUS: bus.rdata = w_status;
        default:    bus.rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller against a queue-based reference model.
module tb_io_controller;
  localparam int         DEPTH     = 4;
  localparam logic [7:0] EMPTY_VAL = 8'hFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_controller_if bus();
`ifdef IO_CTRL_IRQ_EN
  logic irq;
`endif

  io_controller #(.DEPTH(DEPTH), .RD_EMPTY_VAL(EMPTY_VAL)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef IO_CTRL_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_tx_ovf;
  bit         m_rx_ovf;
  bit         m_irq;
  int         m_stall;
  int         n_chk;
  int         n_bad;

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (tx_q.size() == DEPTH);
    s[1] = (rx_q.size() == 0);
    s[2] = m_tx_ovf;
    s[3] = m_rx_ovf;
`ifdef IO_CTRL_IRQ_EN
    s[4] = m_irq;
`endif
    return s;
  endfunction

  function automatic logic [7:0] exp_rdata();
    logic [7:0] v;
    v = 8'h00;
    if (bus.mem_io && bus.rd) begin
      if (bus.addr == 8'h01)      v = (rx_q.size() != 0) ? rx_q[0] : EMPTY_VAL;
      else if (bus.addr == 8'h02) v = exp_status();
    end
    return v;
  endfunction

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    m_tx_ovf = 0;
    m_rx_ovf = 0;
    m_irq    = 0;
    m_stall  = 0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus, then step the DUT.
  task automatic tick();
    bit tx_full, rx_full, tx_pop, rx_push, irq_nxt;
    if (!rst_n) begin
      model_clear();
    end else begin
      tx_full = (tx_q.size() == DEPTH);
      rx_full = (rx_q.size() == DEPTH);
      tx_pop  = (tx_q.size() != 0) && bus.tx_ready;
      rx_push = bus.rx_valid && !rx_full;
      irq_nxt = (rx_q.size() != 0) || m_rx_ovf || m_tx_ovf;
      if (bus.rx_valid && rx_full) m_stall++;
      else                         m_stall = 0;
      if (tx_pop) void'(tx_q.pop_front());
      if (bus.mem_io && bus.wr) begin
        if (bus.addr == 8'h00) begin
          if (tx_full && !tx_pop) m_tx_ovf = 1;
          else                    tx_q.push_back(bus.wdata);
        end else if (bus.addr == 8'h02) begin
          m_tx_ovf = 0;
          m_rx_ovf = 0;
        end
      end else if (bus.mem_io && bus.rd && bus.addr == 8'h01 && rx_q.size() != 0) begin
        void'(rx_q.pop_front());
      end
      if (m_stall >= 256) m_rx_ovf = 1;
      if (rx_push) rx_q.push_back(bus.rx_data);
      m_irq = irq_nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_io   = 1'b0;
    bus.addr     = 8'h00;
    bus.wr       = 1'b0;
    bus.rd       = 1'b0;
    bus.wdata    = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.mem_io = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
    tick();
    bus.mem_io = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic cpu_read_setup(input logic [7:0] a);
    bus.mem_io = 1'b1; bus.wr = 1'b0; bus.rd = 1'b1; bus.addr = a;
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    n_chk++; if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
    n_chk++; if (bus.rdata_oe !== 1'b0) begin n_bad++; $display("FAIL reset_rdata_oe got=%b exp=0", bus.rdata_oe); end
    n_chk++; if (bus.rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
`ifdef IO_CTRL_IRQ_EN
    n_chk++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
    rst_n = 1'b1;
    cpu_read_setup(8'h02);
    n_chk++; if (bus.rdata !== 8'h02) begin n_bad++; $display("FAIL reset_status got=%h exp=02", bus.rdata); end
    n_chk++; if (bus.rdata_oe !== 1'b1) begin n_bad++; $display("FAIL reset_status_oe got=%b exp=1", bus.rdata_oe); end
    tick();
    idle();
  endtask

  task automatic test_tx_order();
    logic [7:0] seq [2];
    seq[0] = 8'h2A;
    seq[1] = 8'h55;
    bus.mem_io = 1'b1; bus.wr = 1'b1; bus.addr = 8'h00; bus.wdata = 8'h2A;
    #1;
    n_chk++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_latency got=%b exp=0", bus.tx_valid); end
    tick();
    bus.wdata = 8'h55;
    #1;
    n_chk++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h2A) begin n_bad++; $display("FAIL tx_first got=%b/%h exp=1/2a", bus.tx_valid, bus.tx_data); end
    tick();
    idle();
    tick();
    n_chk++; if (bus.tx_data !== 8'h2A) begin n_bad++; $display("FAIL tx_hold got=%h exp=2a", bus.tx_data); end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i < 2) begin
        n_chk++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== seq[i]) begin n_bad++; $display("FAIL tx_drain%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, seq[i]); end
      end else begin
        n_chk++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_drained got=%b exp=0", bus.tx_valid); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_tx_overflow();
    bus.rx_valid = 1'b1; bus.rx_data = 8'($urandom_range(0, 255));
    tick();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) cpu_write(8'h00, 8'($urandom_range(0, 127)));
    cpu_write(8'h00, 8'h99);
    cpu_read_setup(8'h02);
    n_chk++; if (bus.rdata !== exp_status()) begin n_bad++; $display("FAIL txovf_status got=%h exp=%h", bus.rdata, exp_status()); end
`ifndef IO_CTRL_IRQ_EN
    n_chk++; if (bus.rdata !== 8'h05) begin n_bad++; $display("FAIL txovf_status_const got=%h exp=05", bus.rdata); end
`endif
    tick();
    cpu_write(8'h02, 8'h00);
    cpu_read_setup(8'h02);
    n_chk++; if (bus.rdata !== exp_status()) begin n_bad++; $display("FAIL txovf_clear got=%h exp=%h", bus.rdata, exp_status()); end
    n_chk++; if (bus.rdata[2] !== 1'b0 || bus.rdata[0] !== 1'b1) begin n_bad++; $display("FAIL txovf_clear_bits got=%h exp=x1", bus.rdata); end
    tick();
    idle();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1;
      n_chk++; if (bus.tx_valid !== (tx_q.size() != 0)) begin n_bad++; $display("FAIL txovf_valid%0d got=%b exp=%b", i, bus.tx_valid, tx_q.size() != 0); end
      if (tx_q.size() != 0) begin
        n_chk++; if (bus.tx_data !== tx_q[0] || bus.tx_data === 8'h99) begin n_bad++; $display("FAIL txovf_data%0d got=%h exp=%h", i, bus.tx_data, tx_q[0]); end
      end
      tick();
    end
    idle();
    cpu_read_setup(8'h01);
    n_chk++; if (bus.rdata !== exp_rdata()) begin n_bad++; $display("FAIL txovf_rxpop got=%h exp=%h", bus.rdata, exp_rdata()); end
    tick();
    idle();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) cpu_write(8'h00, 8'($urandom_range(0, 255)));
    bus.tx_ready = 1'b1;
    cpu_write(8'h00, 8'hA5);
    idle();
    cpu_read_setup(8'h02);
    n_chk++; if (bus.rdata !== exp_status()) begin n_bad++; $display("FAIL fpp_status got=%h exp=%h", bus.rdata, exp_status()); end
    n_chk++; if (bus.rdata[0] !== 1'b1 || bus.rdata[2] !== 1'b0) begin n_bad++; $display("FAIL fpp_full_noovf got=%h exp=full,no-ovf", bus.rdata); end
    tick();
    idle();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_chk++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== tx_q[0]) begin n_bad++; $display("FAIL fpp_data%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, tx_q[0]); end
      tick();
    end
    n_chk++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty got=%b exp=0", bus.tx_valid); end
    idle();
  endtask

  task automatic test_rx_empty_read();
    cpu_read_setup(8'h01);
    n_chk++; if (bus.rdata !== EMPTY_VAL || bus.rdata_oe !== 1'b1) begin n_bad++; $display("FAIL rx_empty_read got=%h/%b exp=ff/1", bus.rdata, bus.rdata_oe); end
    tick();
    idle();
    bus.rx_valid = 1'b1; bus.rx_data = 8'h07;
    tick();
    idle();
    cpu_read_setup(8'h01);
    n_chk++; if (bus.rdata !== 8'h07) begin n_bad++; $display("FAIL rx_read07 got=%h exp=07", bus.rdata); end
    tick();
    cpu_read_setup(8'h02);
    n_chk++; if (bus.rdata[1] !== 1'b1 || bus.rdata !== exp_status()) begin n_bad++; $display("FAIL rx_after_pop got=%h exp=%h", bus.rdata, exp_status()); end
    tick();
    idle();
  endtask

  task automatic test_rx_stall();
    int first;
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 20 && rx_q.size() < DEPTH; k++) begin
      bus.rx_data = 8'($urandom_range(0, 255));
      tick();
    end
    first = -1;
    cpu_read_setup(8'h02);
    for (int k = 0; k < 300; k++) begin
      n_chk++; if (bus.rdata !== exp_status()) begin n_bad++; $display("FAIL stall_status%0d got=%h exp=%h", k, bus.rdata, exp_status()); end
      if (first < 0 && bus.rdata[3] === 1'b1) first = k;
      tick();
      if (first >= 0 && k > first) break;
    end
    n_chk++; if (first !== 256) begin n_bad++; $display("FAIL stall_cycles got=%0d exp=256", first); end
`ifdef IO_CTRL_IRQ_EN
    n_chk++; if (bus.rdata !== 8'h18 || irq !== 1'b1) begin n_bad++; $display("FAIL stall_status_irq got=%h/%b exp=18/1", bus.rdata, irq); end
`else
    n_chk++; if (bus.rdata !== 8'h08) begin n_bad++; $display("FAIL stall_status_const got=%h exp=08", bus.rdata); end
`endif
    bus.rx_valid = 1'b0;
    bus.mem_io   = 1'b0;
    bus.addr     = 8'h01;
    #1;
    n_chk++; if (bus.rdata_oe !== 1'b0 || bus.rdata !== 8'h00) begin n_bad++; $display("FAIL memcycle_read got=%b/%h exp=0/00", bus.rdata_oe, bus.rdata); end
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read_setup(8'h01);
      n_chk++; if (bus.rdata !== rx_q[0]) begin n_bad++; $display("FAIL stall_drain%0d got=%h exp=%h", i, bus.rdata, rx_q[0]); end
      tick();
    end
    idle();
    cpu_write(8'h02, 8'hFF);
    idle();
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 3000; n++) begin
      bus.mem_io   = ($urandom_range(0, 3) != 0);
      op           = $urandom_range(0, 15);
      bus.wr       = (op < 4) || (op == 15);
      bus.rd       = ((op >= 4) && (op < 10)) || (op == 15);
      case ($urandom_range(0, 5))
        0: bus.addr = 8'h00;
        1: bus.addr = 8'h01;
        2: bus.addr = 8'h01;
        3: bus.addr = 8'h02;
        4: bus.addr = 8'h03;
        default: bus.addr = 8'($urandom_range(0, 255));
      endcase
      bus.wdata    = 8'($urandom_range(0, 255));
      bus.tx_ready = ($urandom_range(0, 2) == 0);
      bus.rx_valid = ($urandom_range(0, 1) == 1);
      bus.rx_data  = 8'($urandom_range(0, 255));
      #1;
      n_chk++; if (bus.rdata_oe !== (bus.mem_io && bus.rd)) begin n_bad++; $display("FAIL rnd_oe%0d got=%b exp=%b", n, bus.rdata_oe, bus.mem_io && bus.rd); end
      n_chk++; if (bus.rdata !== exp_rdata()) begin n_bad++; $display("FAIL rnd_rdata%0d got=%h exp=%h", n, bus.rdata, exp_rdata()); end
      n_chk++; if (bus.tx_valid !== (tx_q.size() != 0) || bus.rx_ready !== (rx_q.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_flow%0d got=%b/%b exp=%b/%b", n, bus.tx_valid, bus.rx_ready, tx_q.size() != 0, rx_q.size() < DEPTH); end
      if (tx_q.size() != 0) begin
        n_chk++; if (bus.tx_data !== tx_q[0]) begin n_bad++; $display("FAIL rnd_txdata%0d got=%h exp=%h", n, bus.tx_data, tx_q[0]); end
      end
`ifdef IO_CTRL_IRQ_EN
      n_chk++; if (irq !== m_irq) begin n_bad++; $display("FAIL rnd_irq%0d got=%b exp=%b", n, irq, m_irq); end
`endif
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle();
    for (int i = 0; i < 3; i++) cpu_write(8'h00, 8'($urandom_range(0, 255)));
    bus.rx_valid = 1'b1; bus.rx_data = 8'h3C;
    tick();
    idle();
    bus.tx_ready = 1'b1;
    cpu_read_setup(8'h02);
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_flow got=%b/%b exp=0/1", bus.tx_valid, bus.rx_ready); end
    n_chk++; if (bus.rdata !== 8'h02 || bus.rdata_oe !== 1'b1) begin n_bad++; $display("FAIL midrst_status got=%h/%b exp=02/1", bus.rdata, bus.rdata_oe); end
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    n_chk++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL postrst_tx got=%b exp=0", bus.tx_valid); end
    cpu_read_setup(8'h01);
    n_chk++; if (bus.rdata !== EMPTY_VAL) begin n_bad++; $display("FAIL postrst_rx got=%h exp=ff", bus.rdata); end
    tick();
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_full_push_pop();
    test_rx_empty_read();
    test_rx_stall();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/io_controller.md
# io_controller

Memory-mapped I/O controller on the 8-bit machine's shared data bus, replacing the fixed $FF input stub. It decodes CPU I/O cycles (mem_io high) and buffers CPU output bytes in a TX FIFO drained by a valid/ready stream. It also buffers incoming bytes in an RX FIFO that the CPU pops through an input register, and exposes a status register. The top level muxes its read data onto the bus exactly as it does for RAM.

## Interface
- DEPTH, 4: entries per FIFO; power of two, 2..16.
- RD_EMPTY_VAL, 8'hFF: data returned when the CPU reads an empty RX FIFO.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset: low clears all state immediately, and release is synchronous to clk.
- mem_io  in  1  current CPU bus cycle is an I/O cycle.
- addr  in  8  CPU address bus.
- wr  in  1  CPU write strobe (c_ri), one cycle per access.
- rd  in  1  CPU read strobe (c_ro), one cycle per access.
- wdata  in  8  CPU bus value during writes.
- rdata  out  8  read data.
- rdata_oe  out  1  controller drives the bus this cycle.
- tx_valid / tx_data / tx_ready  out/out/in  1/8/1  output byte stream.
- rx_valid / rx_data / rx_ready  in/in/out  1/8/1  input byte stream.
- irq  out  1  present only with IO_CTRL_IRQ_EN.

## Operation
- The register map is decoded only when mem_io=1:
  - $00 DATA_OUT: write pushes wdata into TX; read returns 8'h00.
  - $01 DATA_IN: read returns the RX head, or RD_EMPTY_VAL if RX is empty, and pops one entry; write is ignored.
  - $02 STATUS: read returns {4'b0, rx_ovf, tx_ovf, rx_empty, tx_full}; a write of any value clears both overflow bits.
  - Any other address: read returns 8'h00 with rdata_oe=1; write is ignored.
- rdata_oe = mem_io & rd & (addr is any of the above); it is combinational and never asserted for memory cycles.
- A TX push while TX is full drops the byte and sets sticky tx_ovf.
- An RX beat accepted while RX is full cannot occur: rx_ready = !rx_full.
- Overflow sticky bits:
  - rx_ovf sets when rx_valid is held high for 256 consecutive cycles with rx_ready low. An 8-bit stall counter, saturating, clears on any accepted beat.
  - tx_ovf sets as described above for a dropped TX push.
- Each FIFO keeps read/write pointers plus a count. Pointers wrap modulo DEPTH, and count runs 0..DEPTH.
- wr and rd asserted together are illegal. The controller performs the write only.

## Timing
- TX:
  - A push on edge N makes tx_valid high after edge N (latency 1).
  - tx_data always presents the TX head and is stable while tx_valid=1 and tx_ready=0.
  - A pop occurs on the edge where tx_valid & tx_ready.
- RX:
  - A beat is accepted on the edge where rx_valid & rx_ready.
  - The byte is readable at $01 from the next cycle.
- Reads: rdata is combinational in the strobe cycle. The RX pop commits on that cycle's clk edge.
- Simultaneous push and pop on a full FIFO: both occur, count is unchanged, and no overflow is flagged.
- Simultaneous push and pop on an empty FIFO: push only, since the pop is gated by emptiness.
- Simultaneous STATUS write and a new overflow event: the set wins.
- Reset values:
  - Pointers and counts 0, tx_valid 0, rx_ready 1.
  - rdata 8'h00 (while rdata_oe is 0), rdata_oe 0.
  - Overflow bits 0, stall counter 0, irq 0.
  - Reset mid-transfer discards all FIFO contents.

## Configuration
- IO_CTRL_IRQ_EN defined:
  - Adds output irq, registered, set one cycle after RX becomes non-empty or any overflow bit sets.
  - Cleared one cycle after RX is empty and both overflow bits are clear.
  - Adds STATUS bit 4 = irq.
- IO_CTRL_IRQ_EN undefined: no irq port, and STATUS bit 4 reads 0.

## Structure
- Package io_pkg holds:
  - Address constants IO_ADDR_OUT=$00, IO_ADDR_IN=$01, IO_ADDR_STATUS=$02.
  - STATUS bit-index localparams.
  - The DEPTH legality check function.
- One sub-module, io_fifo (parameters WIDTH, DEPTH), instantiated twice for TX and RX. It exposes push, pop, full, empty, count and head.
- Address decode, status logic, overflow logic and the optional irq live in io_controller.

## Test plan
- Reset low mid-stream with TX holding 3 bytes -> tx_valid=0, rx_ready=1 and STATUS reads $02 immediately; after release the FIFOs are empty.
- Write $2A and then $55 to $00 with tx_ready=0; then raise tx_ready -> tx_data shows $2A then $55 on consecutive cycles, then tx_valid=0.
- Fill TX with 4 writes (DEPTH=4), then write $99 -> STATUS=$05 and $99 is never emitted. Write $00 to $02 -> STATUS=$01.
- Read $01 while RX is empty -> rdata=$FF, rdata_oe=1 and no pointer change. Then inject $07 and read $01 -> $07; STATUS rx_empty=1 afterwards.
- Hold rx_valid with RX full for 256 cycles -> rx_ovf=1, STATUS=$08 (TX not full). With IO_CTRL_IRQ_EN, irq=1 one cycle later.
- Read with mem_io=0 at addr $01 -> rdata_oe=0 and RX unchanged. TX full with push and pop in the same cycle -> count stays 4 and tx_ovf stays 0.
